// File: rtl/rca_pkg.sv
// Shared definitions for the shared ripple-carry adder sequencer.
package rca_pkg;

    localparam int SLICE_W   = 32;
    localparam int MAX_WORDS = 16;
    localparam int MAX_W     = SLICE_W * MAX_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Pick 32-bit slice number idx out of a widest-case operand vector.
    function automatic logic [SLICE_W-1:0] sliceSel(input logic [MAX_W-1:0] vec,
                                                    input int unsigned      idx);
        return vec[SLICE_W*idx +: SLICE_W];
    endfunction

endpackage

// File: rtl/fulladdr_32_bit.sv
// 32-bit adder slice with carry in and carry out, shared by all requesters.
module fulladdr_32_bit (
    output logic [31:0] sum,
    output logic        c_out,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};

endmodule

// File: rtl/rca_share_ctrl.sv
// Round-robin sequencer that shares one 32-bit adder between two requesters,
// processing a WORDS-slice add one slice per cycle, least-significant first.
module rca_share_ctrl
    import rca_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [SLICE_W*WORDS-1:0]   req0_a,
    input  logic [SLICE_W*WORDS-1:0]   req0_b,
    input  logic                       req0_cin,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [SLICE_W*WORDS-1:0]   req1_a,
    input  logic [SLICE_W*WORDS-1:0]   req1_b,
    input  logic                       req1_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [SLICE_W*WORDS-1:0]   rsp_sum,
    output logic                       rsp_cout
);

    localparam int N     = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e             state_q;
    logic [N-1:0]       opA_q;
    logic [N-1:0]       opB_q;
    logic [N-1:0]       sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               id_q;
    logic               last_q;

    logic               grantId_d;
    logic               grantGo_d;
    logic [N-1:0]       selA_d;
    logic [N-1:0]       selB_d;
    logic               selCin_d;
    logic [SLICE_W-1:0] adderA;
    logic [SLICE_W-1:0] adderB;
    logic [SLICE_W-1:0] adderSum;
    logic               adderCout;

    // Grant picks the non-last requester under contention, else whichever is valid.
    always_comb begin
        grantId_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grantId_d = ~last_q;
        end else if (req1_valid) begin
            grantId_d = 1'b1;
        end
        grantGo_d = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
        selA_d    = grantId_d ? req1_a   : req0_a;
        selB_d    = grantId_d ? req1_b   : req0_b;
        selCin_d  = grantId_d ? req1_cin : req0_cin;
    end

    assign req0_ready = grantGo_d && !grantId_d;
    assign req1_ready = grantGo_d &&  grantId_d;

    assign adderA = sliceSel(MAX_W'(opA_q), 32'(idx_q));
    assign adderB = sliceSel(MAX_W'(opB_q), 32'(idx_q));

    fulladdr_32_bit u_adder (
        .sum   (adderSum),
        .c_out (adderCout),
        .a     (adderA),
        .b     (adderB),
        .c_in  (carry_q)
    );

    // Control FSM plus operand capture, slice write-back and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grantGo_d) begin
                        opA_q   <= selA_d;
                        opB_q   <= selB_d;
                        carry_q <= selCin_d;
                        id_q    <= grantId_d;
                        last_q  <= grantId_d;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q*SLICE_W +: SLICE_W] <= adderSum;
                    carry_q <= adderCout;
                    if (idx_q == IDX_W'(WORDS-1)) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_rca_share_ctrl.sv
// Self-checking bench for rca_share_ctrl with WORDS = 4.
module tb_rca_share_ctrl;

    localparam int WORDS = 4;
    localparam int N     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [N-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [N-1:0] rsp_sum;

    int vectors     = 0;
    int miscompares = 0;
    int cycleCount  = 0;
    bit lastModel;

    rca_share_ctrl #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
    );

    // Free-running clock and cycle counter used for latency/throughput checks.
    always #5 clk = ~clk;
    always @(posedge clk) cycleCount++;

    // Reference: full-width unsigned add, carry-out in the top bit.
    function automatic logic [N:0] refAdd(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic cin);
        return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    endfunction

    // Reference: round-robin choice between the requesters.
    function automatic bit refGrant(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    function automatic logic [N-1:0] randWide();
        logic [N-1:0] v;
        for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input bit which, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin);
        if (which) begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        end
    endtask

    // Wait for a request handshake; returns at 1 time unit after the grant edge.
    task automatic waitGrant(output bit gid, output int gcyc, output bit ok);
        ok = 1'b0; gid = 1'b0; gcyc = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                gid = req1_ready;
                @(posedge clk);
                #1;
                gcyc = cycleCount;
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges from the grant until rsp_valid is seen; notes any ready leak.
    task automatic waitResponse(output int lat, output bit ok, output bit leak);
        lat = 0; ok = 1'b0; leak = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (req0_ready || req1_ready) leak = 1'b1;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic runOp(input bit handshake, output bit gid, output int gcyc, output int lat,
                         output bit ok, output bit leak, output logic [N:0] res,
                         output logic id);
        bit gok;
        ok = 1'b0; lat = 0; leak = 1'b0; res = '0; id = 1'b0;
        waitGrant(gid, gcyc, gok);
        if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (!gok) return;
        waitResponse(lat, ok, leak);
        res = {rsp_cout, rsp_sum};
        id  = rsp_id;
        if (ok && handshake) begin
            rsp_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [N-1:0] a0, b0, a1, b1;
        logic [N:0]   exp;
        int lat; bit ok, leak;
        a0 = randWide(); b0 = randWide(); a1 = randWide(); b1 = randWide();
        rst_n = 1'b0; rsp_ready = 1'b0;
        setReq(0, a0, b0, 1'b1);
        setReq(1, a1, b1, 1'b0);
        repeat (2) tick();
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            miscompares++; $display("[TB] FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_cout} !== 3'b000 || rsp_sum !== '0) begin
            miscompares++; $display("[TB] FAIL reset_rsp: got v%b id%b c%b sum %h expected zeros", rsp_valid, rsp_id, rsp_cout, rsp_sum);
        end
        rst_n = 1'b1;
        lastModel = 1'b1;
        #1;
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            miscompares++; $display("[TB] FAIL first_grant: got %b expected 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        lastModel = 1'b0;
        exp = refAdd(a0, b0, 1'b1);
        waitResponse(lat, ok, leak);
        vectors++;
        if (!ok || lat !== 4) begin
            miscompares++; $display("[TB] FAIL first_latency: got %0d (ok=%b) expected 4", lat, ok);
        end
        vectors++;
        if ({rsp_cout, rsp_sum} !== exp || rsp_id !== 1'b0) begin
            miscompares++; $display("[TB] FAIL first_result: got %h id %b expected %h id 0", {rsp_cout, rsp_sum}, rsp_id, exp);
        end
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_carry_chain();
        bit gid, ok, leak; int gcyc, lat; logic [N:0] res; logic id;
        setReq(0, {N{1'b1}}, N'(1), 1'b0);
        runOp(1'b1, gid, gcyc, lat, ok, leak, res, id);
        vectors++;
        if (!ok || res !== {1'b1, {N{1'b0}}} || id !== 1'b0) begin
            miscompares++; $display("[TB] FAIL carry_chain: got %h id %b expected %h id 0", res, id, {1'b1, {N{1'b0}}});
        end
        vectors++;
        if (lat !== 4 || leak) begin
            miscompares++; $display("[TB] FAIL carry_chain_timing: got lat %0d leak %b expected 4 0", lat, leak);
        end
        lastModel = 1'b0;
    endtask

    task automatic test_fixed_req1();
        logic [N-1:0] a, b; logic [N:0] exp, res;
        bit gid, ok, leak; int gcyc, lat; logic id;
        a = {4{32'hAFAFAAFF}}; b = {4{32'hAEBAEBFF}};
        exp = refAdd(a, b, 1'b1);
        setReq(1, a, b, 1'b1);
        runOp(1'b1, gid, gcyc, lat, ok, leak, res, id);
        vectors++;
        if (!ok || res !== exp || id !== 1'b1 || gid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL req1_fixed: got %h id %b expected %h id 1", res, id, exp);
        end
        lastModel = 1'b1;
    endtask

    task automatic test_contention();
        logic [N-1:0] opA [2]; logic [N-1:0] opB [2]; logic opC [2];
        logic [N:0] exp, res; logic id;
        bit gid, ok, leak, expId; int gcyc, lat, prevCyc;
        rsp_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            opA[r] = randWide(); opB[r] = randWide(); opC[r] = 1'($urandom);
            setReq(r[0], opA[r], opB[r], opC[r]);
        end
        prevCyc = 0;
        for (int i = 0; i < 4; i++) begin
            expId = refGrant(1'b1, 1'b1, lastModel);
            runOp(1'b1, gid, gcyc, lat, ok, leak, res, id);
            exp = refAdd(opA[expId], opB[expId], opC[expId]);
            vectors++;
            if (!ok || gid !== expId || id !== expId) begin
                miscompares++; $display("[TB] FAIL contend_id[%0d]: got grant %b rsp_id %b expected %b", i, gid, id, expId);
            end
            vectors++;
            if (res !== exp || lat !== 4 || leak) begin
                miscompares++; $display("[TB] FAIL contend_result[%0d]: got %h lat %0d leak %b expected %h lat 4", i, res, lat, leak, exp);
            end
            if (i > 0) begin
                vectors++;
                if (gcyc - prevCyc !== WORDS + 2) begin
                    miscompares++; $display("[TB] FAIL contend_period[%0d]: got %0d expected %0d", i, gcyc - prevCyc, WORDS + 2);
                end
            end
            prevCyc = gcyc;
            lastModel = expId;
            opA[gid] = randWide(); opB[gid] = randWide(); opC[gid] = 1'($urandom);
            setReq(gid, opA[gid], opB[gid], opC[gid]);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] a, b, a1, b1; logic [N:0] exp, exp1, res; logic id;
        bit gid, ok, leak, stable; int gcyc, lat, hsCyc;
        a = randWide(); b = randWide(); a1 = randWide(); b1 = randWide();
        exp = refAdd(a, b, 1'b0); exp1 = refAdd(a1, b1, 1'b1);
        rsp_ready = 1'b0;
        setReq(0, a, b, 1'b0);
        runOp(1'b0, gid, gcyc, lat, ok, leak, res, id);
        lastModel = 1'b0;
        vectors++;
        if (!ok || res !== exp || id !== 1'b0) begin
            miscompares++; $display("[TB] FAIL bp_result: got %h id %b expected %h id 0", res, id, exp);
        end
        setReq(1, a1, b1, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== exp || rsp_id !== 1'b0 || req1_ready !== 1'b0)
                stable = 1'b0;
        end
        vectors++;
        if (!stable) begin
            miscompares++; $display("[TB] FAIL bp_hold: got stable=%b expected 1", stable);
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req1_ready !== 1'b0) begin
            miscompares++; $display("[TB] FAIL bp_no_overlap: got req1_ready %b expected 0", req1_ready);
        end
        @(posedge clk);
        #1;
        hsCyc = cycleCount;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL bp_release: got rsp_valid %b expected 0", rsp_valid);
        end
        runOp(1'b1, gid, gcyc, lat, ok, leak, res, id);
        lastModel = 1'b1;
        vectors++;
        if (!ok || gid !== 1'b1 || gcyc !== hsCyc + 1) begin
            miscompares++; $display("[TB] FAIL bp_next_grant: got id %b cycle +%0d expected id 1 cycle +1", gid, gcyc - hsCyc);
        end
        vectors++;
        if (res !== exp1 || id !== 1'b1) begin
            miscompares++; $display("[TB] FAIL bp_req1_result: got %h id %b expected %h id 1", res, id, exp1);
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] a, b; logic [N:0] exp, res; logic id;
        bit gid, ok, leak, stale; int gcyc, lat;
        setReq(1, randWide(), randWide(), 1'b1);
        waitGrant(gid, gcyc, ok);
        req1_valid = 1'b0;
        vectors++;
        if (!ok || gid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL ar_grant: got %b ok %b expected 1", gid, ok);
        end
        repeat (2) tick();
        setReq(0, randWide(), randWide(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready} !== 5'b0 || rsp_sum !== '0) begin
            miscompares++; $display("[TB] FAIL ar_immediate: got v%b id%b c%b r%b%b sum %h expected zeros", rsp_valid, rsp_id, rsp_cout, req1_ready, req0_ready, rsp_sum);
        end
        req0_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        lastModel = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid !== 1'b0) stale = 1'b1;
        end
        vectors++;
        if (stale) begin
            miscompares++; $display("[TB] FAIL ar_stale: got stale response %b expected 0", stale);
        end
        a = randWide(); b = randWide();
        exp = refAdd(a, b, 1'b1);
        rsp_ready = 1'b1;
        setReq(0, a, b, 1'b1);
        runOp(1'b1, gid, gcyc, lat, ok, leak, res, id);
        lastModel = 1'b0;
        vectors++;
        if (!ok || res !== exp || id !== 1'b0 || lat !== 4) begin
            miscompares++; $display("[TB] FAIL ar_recover: got %h id %b lat %0d expected %h id 0 lat 4", res, id, lat, exp);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] opA [2]; logic [N-1:0] opB [2]; logic opC [2];
        logic [N:0] exp, res; logic id;
        bit gid, ok, leak, expId; int gcyc, lat, pat, delay;
        for (int i = 0; i < 16; i++) begin
            pat = $urandom_range(1, 3);
            for (int r = 0; r < 2; r++) begin
                opA[r] = ($urandom_range(0, 3) == 0) ? {N{1'b1}} : randWide();
                opB[r] = ($urandom_range(0, 3) == 0) ? N'(1) : randWide();
                opC[r] = 1'($urandom);
                if (pat[r]) setReq(r[0], opA[r], opB[r], opC[r]);
            end
            expId = refGrant(pat[0], pat[1], lastModel);
            exp = refAdd(opA[expId], opB[expId], opC[expId]);
            rsp_ready = 1'b0;
            runOp(1'b0, gid, gcyc, lat, ok, leak, res, id);
            req0_valid = 1'b0; req1_valid = 1'b0;
            lastModel = expId;
            vectors++;
            if (!ok || gid !== expId || id !== expId || res !== exp || lat !== 4 || leak) begin
                miscompares++; $display("[TB] FAIL random[%0d]: got id %b %h lat %0d expected id %b %h lat 4", i, id, res, lat, expId, exp);
            end
            delay = $urandom_range(0, 3);
            repeat (delay) tick();
            vectors++;
            if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== exp) begin
                miscompares++; $display("[TB] FAIL random_hold[%0d]: got v%b %h expected v1 %h", i, rsp_valid, {rsp_cout, rsp_sum}, exp);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready = 1'b0; rst_n = 1'b0;
        lastModel = 1'b1;
        test_reset();
        test_carry_chain();
        test_fixed_req1();
        test_contention();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global bound so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rca_share_ctrl.md
# rca_share_ctrl

Sequencer and arbiter that shares one `fulladdr_32_bit` ripple-carry adder between two requesters. Each requester submits a multi-word add. The block grants one request at a time in round-robin order and feeds the adder one 32-bit slice per cycle, least-significant slice first, with the carry registered between slices. It returns the full-width sum and carry-out over a valid/ready response channel. It sits between the requesting datapath units and the single shared adder instance.

## Interface
- `WORDS`, default 4: number of 32-bit slices per operand; operand width N = 32*WORDS; legal range 2..16.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0 granted; operands captured this cycle.
- `req0_a`, `req0_b`  in  N  requester 0 operands.
- `req0_cin`  in  1  requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as the requester 0 ports, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_sum`  out  N  sum.
- `rsp_cout`  out  1  carry out of the top slice.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `reqX_ready` = 1 for the granted requester only. The grant is combinational from `req*_valid` and the `last` pointer.
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not `last`.
  - On handshake, capture a, b, cin and id into registers, set slice index `idx` = 0, set `carry` = cin, update `last` = id, and go to RUN.
  - No requester valid: stay in IDLE.
- RUN, each cycle:
  - Adder inputs are a[32*idx +: 32], b[32*idx +: 32] and `carry`.
  - Write the adder sum into sum slice `idx`. Set `carry` = adder c_out. Increment `idx`.
  - When `idx` == WORDS-1, go to DONE and do not increment.
- DONE:
  - `rsp_valid` = 1; `rsp_sum`, `rsp_cout` and `rsp_id` hold stable.
  - On `rsp_ready` = 1, go to IDLE.
  - `req*_ready` = 0 in DONE and in RUN.
- Arithmetic is unsigned modulo 2^N. `rsp_cout` is the carry out of bit N-1. No overflow flag is produced.
- The adder instance is always driven. Its output is ignored outside RUN.

## Timing
- Reset values: `req0_ready` = `req1_ready` = 0 while `rst_n` = 0; `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `idx` = 0, `carry` = 0.
- The `last` pointer resets to 1, so requester 0 wins the first contended grant.
- Latency:
  - Request handshake at edge k.
  - Slices are computed at edges k+1 … k+WORDS.
  - `rsp_valid` is high after edge k+WORDS.
  - With `rsp_ready` tied high, throughput is one operation per WORDS+2 cycles.
- Response backpressure: while `rsp_ready` = 0 the block stays in DONE indefinitely. Pending requests wait, and their operands must be held stable by the requester until `ready`.
- A response handshake and a new request grant never occur in the same cycle. The next grant is possible in the cycle after DONE→IDLE.
- Requester valid/ready: `valid` must stay high with stable operands until `ready`. Dropping `valid` before grant is permitted; the request is simply not taken.
- Contention in consecutive operations alternates the grant 0,1,0,1. A lone requester is granted back-to-back regardless of `last`.
- `idx` wraps only via return to IDLE. It never exceeds WORDS-1.
- Asynchronous reset mid-RUN or mid-DONE:
  - The operation is abandoned and no response is issued.
  - All outputs take their reset values immediately.
  - Operation resumes in IDLE after `rst_n` deasserts.

## Structure
- Shared package `rca_pkg`:
  - constant SLICE_W = 32.
  - FSM state enum {IDLE, RUN, DONE}.
  - helper function for slice select.
- One sub-module is natural: the existing `fulladdr_32_bit`, instantiated once (sum, c_out, a, b, c_in port order). It is not modified.
- Arbitration is kept inline (two requesters). No separate arbiter module is needed.

## Test plan
All scenarios use WORDS = 4.
1. Reset with both requesters valid, release `rst_n` → first grant goes to requester 0; `rsp_valid` rises exactly 4 cycles after the grant edge.
2. req0: a = all-ones (128 b), b = 1, cin = 0 → `rsp_sum` = 0, `rsp_cout` = 1, `rsp_id` = 0. This exercises carry propagation across all slices.
3. req1: a = {4{32'hAFAFAAFF}}, b = {4{32'hAEBAEBFF}}, cin = 1 → `rsp_sum` = a+b+1 mod 2^128, `rsp_cout` = 1, `rsp_id` = 1.
4. Both requesters held valid for 4 operations, `rsp_ready` = 1 → `rsp_id` sequence 0,1,0,1; each operation takes 6 cycles.
5. `rsp_ready` = 0 for 10 cycles in DONE with req1 valid → response stable, `req1_ready` stays 0; req1 is granted the cycle after the response handshake.
6. Assert `rst_n` = 0 during RUN (idx = 2) → `rsp_valid` = 0 and `rsp_sum` = 0 immediately; after release, a new request completes correctly and no stale response appears.
